// File: rtl/pw_pkg.sv
// Shared types and constants for the password lockout controller.
package pw_pkg;

  localparam int SW_W = 10;

  typedef enum logic [1:0] {
    ST_ARMED    = 2'd0,
    ST_OPEN     = 2'd1,
    ST_LOCKOUT  = 2'd2,
    ST_WAIT_REL = 2'd3
  } pw_state_e;

  localparam logic [2:0] DISP_ARMED    = 3'd0;
  localparam logic [2:0] DISP_OPEN     = 3'd1;
  localparam logic [2:0] DISP_LOCKOUT  = 3'd2;
  localparam logic [2:0] DISP_WAIT_REL = 3'd3;

  function automatic logic [2:0] disp_of(input pw_state_e s);
    case (s)
      ST_OPEN:     return DISP_OPEN;
      ST_LOCKOUT:  return DISP_LOCKOUT;
      ST_WAIT_REL: return DISP_WAIT_REL;
      default:     return DISP_ARMED;
    endcase
  endfunction

endpackage

// File: rtl/pw_sec_timer.sv
// 6-bit loadable seconds down-counter; load beats tick, counting stops at zero.
module pw_sec_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [5:0] load_val,
  input  logic       tick,
  output logic [5:0] cnt,
  output logic       zero
);

  assign zero = (cnt == 6'd0);

  always_ff @(posedge clk) begin
    if (rst)               cnt <= 6'd0;
    else if (load)         cnt <= load_val;
    else if (tick && !zero) cnt <= cnt - 6'd1;
  end

endmodule

// File: rtl/pw_lockout_ctrl.sv
// Password lockout controller: gates switches, counts failures, times lockout/open windows.
// Build option PW_AUTO_RELOCK_EN: OPEN times out after UNLOCK_SECS ticks instead of waiting for switch release.
import pw_pkg::*;

module pw_lockout_ctrl #(
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_SECS   = 30,
  parameter int UNLOCK_SECS = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SW_W-1:0] sw_in,
  input  logic            tick,
  input  logic            pw_ok,
  input  logic            pw_fail,
  output logic [SW_W-1:0] sw_out,
  output logic            pw_clr,
  output logic            unlocked,
  output logic            locked,
  output logic [1:0]      attempts_left,
  output logic [5:0]      secs_left,
  output logic [2:0]      disp_code
);

  localparam logic [1:0] MAX_A    = 2'(MAX_TRIES);
  localparam logic [5:0] LOCK_V   = 6'(LOCK_SECS);
  localparam logic [5:0] UNLOCK_V = 6'(UNLOCK_SECS);

  pw_state_e  state, state_n;
  logic [1:0] att_n;
  logic       clr_req, tmr_load, tmr_zero, expire;
  logic [5:0] tmr_val, cnt;

  pw_sec_timer u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (tick),
    .cnt      (cnt),
    .zero     (tmr_zero)
  );

  assign secs_left = cnt;
  // Last tick of a running window: state leaves on the same edge the count hits zero.
  assign expire    = tick && !tmr_zero && (cnt[5:1] == 5'd0);

  always_comb begin
    state_n  = state;
    att_n    = attempts_left;
    clr_req  = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_ARMED: begin
        if (pw_fail) begin
          clr_req = 1'b1;
          if (attempts_left == 2'd1) begin
            state_n  = ST_LOCKOUT;
            att_n    = 2'd0;
            tmr_load = 1'b1;
            tmr_val  = LOCK_V;
          end else begin
            att_n = attempts_left - 2'd1;
          end
        end else if (pw_ok) begin
          state_n = ST_OPEN;
          att_n   = MAX_A;
          tmr_val = UNLOCK_V;
`ifdef PW_AUTO_RELOCK_EN
          tmr_load = 1'b1;
`endif
        end
      end
      ST_OPEN: begin
`ifdef PW_AUTO_RELOCK_EN
        if (expire) state_n = ST_WAIT_REL;
`else
        if (sw_in == '0) begin
          state_n = ST_ARMED;
          clr_req = 1'b1;
        end
`endif
      end
      ST_LOCKOUT: begin
        if (expire) begin
          state_n = ST_WAIT_REL;
          att_n   = MAX_A;
        end
      end
      ST_WAIT_REL: begin
        if (sw_in == '0) begin
          state_n = ST_ARMED;
          clr_req = 1'b1;
        end
      end
      default: state_n = ST_ARMED;
    endcase
  end

  // Flags and display decode from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_ARMED;
      attempts_left <= MAX_A;
      pw_clr        <= 1'b0;
      unlocked      <= 1'b0;
      locked        <= 1'b0;
      disp_code     <= DISP_ARMED;
      sw_out        <= '0;
    end else begin
      state         <= state_n;
      attempts_left <= att_n;
      pw_clr        <= clr_req && !pw_clr;
      unlocked      <= (state_n == ST_OPEN);
      locked        <= (state_n == ST_LOCKOUT);
      disp_code     <= disp_of(state_n);
      sw_out        <= (state_n == ST_ARMED) ? sw_in : '0;
    end
  end

endmodule

// File: tb/tb_pw_lockout_ctrl.sv
// Randomized + directed bench for pw_lockout_ctrl against a behavioural model.
module tb_pw_lockout_ctrl;

  localparam int MAXT = 3;
  localparam int LOCK = 5;
  localparam int UNLK = 4;
`ifdef PW_AUTO_RELOCK_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] sw_in = 10'h0;
  logic       tick = 1'b0, pw_ok = 1'b0, pw_fail = 1'b0;
  logic [9:0] sw_out;
  logic       pw_clr, unlocked, locked;
  logic [1:0] attempts_left;
  logic [5:0] secs_left;
  logic [2:0] disp_code;

  int n_vec = 0;
  int n_bad = 0;

  pw_lockout_ctrl #(.MAX_TRIES(MAXT), .LOCK_SECS(LOCK), .UNLOCK_SECS(UNLK)) dut (
    .clk(clk), .rst(rst), .sw_in(sw_in), .tick(tick), .pw_ok(pw_ok), .pw_fail(pw_fail),
    .sw_out(sw_out), .pw_clr(pw_clr), .unlocked(unlocked), .locked(locked),
    .attempts_left(attempts_left), .secs_left(secs_left), .disp_code(disp_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 ARMED, 1 OPEN, 2 LOCKOUT, 3 WAIT_REL
  int m_mode, m_att, m_secs, m_sw;
  bit m_clr, m_ok = 1'b0;

  always @(posedge clk) begin
    int nxt;
    bit want_clr, fired, loaded;
    if (rst) begin
      m_mode = 0; m_att = MAXT; m_secs = 0; m_clr = 0; m_sw = 0; m_ok = 1'b1;
    end else if (m_ok) begin
      nxt = m_mode; want_clr = 0; loaded = 0;
      fired = tick && (m_secs == 1);
      case (m_mode)
        0: if (pw_fail) begin
             want_clr = 1; m_att = m_att - 1;
             if (m_att == 0) begin nxt = 2; m_secs = LOCK; loaded = 1; end
           end else if (pw_ok) begin
             nxt = 1; m_att = MAXT;
             if (AUTO) begin m_secs = UNLK; loaded = 1; end
           end
        1: if (AUTO) begin
             if (fired) nxt = 3;
           end else if (sw_in == 0) begin
             nxt = 0; want_clr = 1;
           end
        2: if (fired) begin nxt = 3; m_att = MAXT; end
        default: if (sw_in == 0) begin nxt = 0; want_clr = 1; end
      endcase
      if (!loaded && tick && m_secs > 0) m_secs = m_secs - 1;
      m_clr  = want_clr && !m_clr;
      m_mode = nxt;
      m_sw   = (nxt == 0) ? int'(sw_in) : 0;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("sw_out",        sw_out,        m_sw);
      chk("pw_clr",        pw_clr,        m_clr);
      chk("unlocked",      unlocked,      m_mode == 1);
      chk("locked",        locked,        m_mode == 2);
      chk("attempts_left", attempts_left, m_att);
      chk("secs_left",     secs_left,     m_secs);
      chk("disp_code",     disp_code,     m_mode);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic p_ok();   pw_ok = 1;   step(); pw_ok = 0;   endtask
  task automatic p_fail(); pw_fail = 1; step(); pw_fail = 0; endtask
  task automatic p_tick(); tick = 1;    step(); tick = 0;    endtask

  initial begin
    sw_in = 10'h2AA;
    step(); step();
    chk("rst_att", attempts_left, 3);  chk("rst_secs", secs_left, 0);
    chk("rst_disp", disp_code, 0);     chk("rst_sw", sw_out, 0);
    chk("rst_clr", pw_clr, 0);
    rst = 0; sw_in = 10'h155; step();
    chk("armed_sw", sw_out, 10'h155);

    // open window then release
    p_ok();
    chk("open_unl", unlocked, 1); chk("open_disp", disp_code, 1);
    if (AUTO) begin
      chk("open_secs", secs_left, 4);
      for (int i = 1; i <= 3; i++) begin
        p_tick(); step();
        chk("open_cnt", secs_left, 4 - i); chk("open_hold", disp_code, 1);
      end
      p_tick();
      chk("exp_disp", disp_code, 3); chk("exp_secs", secs_left, 0);
      chk("exp_sw", sw_out, 0);      chk("exp_unl", unlocked, 0);
    end else begin
      chk("open_secs0", secs_left, 0);
      for (int i = 0; i < 10; i++) begin p_tick(); step(); end
      chk("open_stay", disp_code, 1); chk("open_secs0b", secs_left, 0);
    end
    sw_in = 0; step();
    chk("rel_disp", disp_code, 0); chk("rel_clr", pw_clr, 1);
    step();
    chk("rel_clr_off", pw_clr, 0);

    // ok+fail same cycle
    sw_in = 10'h155; pw_ok = 1; pw_fail = 1; step(); pw_ok = 0; pw_fail = 0;
    chk("both_att", attempts_left, 2); chk("both_disp", disp_code, 0);
    chk("both_unl", unlocked, 0);      chk("both_clr", pw_clr, 1);
    step();
    chk("both_clr_off", pw_clr, 0);

    // three failures -> lockout
    rst = 1; step(); rst = 0;
    p_fail(); chk("f1", attempts_left, 2); step();
    p_fail(); chk("f2", attempts_left, 1); step();
    p_fail(); chk("f3", attempts_left, 0);
    chk("lk_locked", locked, 1); chk("lk_secs", secs_left, 5); chk("lk_disp", disp_code, 2);
    sw_in = 10'h3FF; step();
    chk("lk_sw", sw_out, 0);
    p_ok(); chk("lk_ign_ok", disp_code, 2);

    // reset mid-lockout
    p_tick(); step(); p_tick();
    chk("lk_secs3", secs_left, 3);
    rst = 1; step(); rst = 0;
    chk("mr_disp", disp_code, 0); chk("mr_att", attempts_left, 3);
    chk("mr_secs", secs_left, 0); chk("mr_clr", pw_clr, 0); chk("mr_lock", locked, 0);

    // lockout expiry with switches held
    p_fail(); step(); p_fail(); step(); p_fail();
    sw_in = 10'h3FF;
    for (int i = 0; i < 5; i++) begin p_tick(); step(); end
    chk("wr_disp", disp_code, 3); chk("wr_att", attempts_left, 3);
    step(); step(); step();
    chk("wr_hold", disp_code, 3);
    sw_in = 0; step();
    chk("wr_disp0", disp_code, 0); chk("wr_clr", pw_clr, 1);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 299) == 0);
      sw_in   = ($urandom_range(0, 3) == 0) ? 10'h0 : 10'($urandom);
      tick    = ($urandom_range(0, 2) == 0);
      pw_ok   = ($urandom_range(0, 6) == 0);
      pw_fail = ($urandom_range(0, 6) == 0);
      step();
    end
    rst = 0; tick = 0; pw_ok = 0; pw_fail = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
